// File: rtl/lut_minterm_enum_if.sv
// Stream and control bundle for lut_minterm_enum: start/busy/done control plus a valid/ready code stream.
// master is the enumerator side; slave is the consumer/controller side.
interface lut_minterm_enum_if #(
   parameter int WIDTH = 4
);
   logic             start;
   logic [WIDTH-1:0] code;
   logic             valid;
   logic             ready;
   logic             busy;
   logic             done;
   logic [WIDTH:0]   count;

   modport master (
      input  start, ready,
      output code, valid, busy, done, count
   );

   modport slave (
      output start, ready,
      input  code, valid, busy, done, count
   );
endinterface

// File: rtl/lut_minterm_enum.sv
// Emits every code whose MASK bit is 1, in ascending order; 1 cycle per index plus 1 per emitted code.
// valid holds code until ready; each ready-low cycle with valid=1 adds one stall cycle.
module lut_minterm_enum #(
   parameter int                  WIDTH = 4,
   parameter logic [2**WIDTH-1:0] MASK  = 16'h0510
) (
   input  logic                clk,
   input  logic                rst,
   lut_minterm_enum_if.master  bus
);
   typedef enum logic [1:0] {IDLE, SCAN, OUT, DONE} state_t;

   localparam logic [WIDTH-1:0] LAST = '1;

   state_t           r_state;
   logic [WIDTH-1:0] r_idx;
   logic [WIDTH-1:0] r_code;
   logic             r_valid;
   logic             r_busy;
   logic             r_done;
   logic [WIDTH:0]   r_count;

   logic w_hit;
   logic w_last;
   logic w_accept;

   assign w_hit    = MASK[r_idx];
   // Termination compares against the last index so idx never wraps.
   assign w_last   = (r_idx == LAST);
   assign w_accept = r_valid & bus.ready;

   always_ff @(posedge clk or posedge rst) begin
      if (rst) begin
         r_state <= IDLE;
         r_idx   <= '0;
         r_code  <= '0;
         r_valid <= 1'b0;
         r_busy  <= 1'b0;
         r_done  <= 1'b0;
         r_count <= '0;
      end else begin
         case (r_state)
            IDLE: begin
               r_done <= 1'b0;
               if (bus.start) begin
                  r_state <= SCAN;
                  r_idx   <= '0;
                  r_count <= '0;
                  r_busy  <= 1'b1;
               end
            end
            SCAN: begin
               if (w_hit) begin
                  r_state <= OUT;
                  r_code  <= r_idx;
                  r_valid <= 1'b1;
               end else if (w_last) begin
                  r_state <= DONE;
                  r_done  <= 1'b1;
               end else begin
                  r_idx <= r_idx + 1'b1;
               end
            end
            OUT: begin
               if (w_accept) begin
                  r_valid <= 1'b0;
                  r_count <= r_count + 1'b1;
                  if (w_last) begin
                     r_state <= DONE;
                     r_done  <= 1'b1;
                  end else begin
                     r_state <= SCAN;
                     r_idx   <= r_idx + 1'b1;
                  end
               end
            end
            DONE: begin
               r_done  <= 1'b0;
               r_busy  <= 1'b0;
               r_state <= IDLE;
            end
            default: begin
               r_state <= IDLE;
               r_valid <= 1'b0;
               r_busy  <= 1'b0;
               r_done  <= 1'b0;
            end
         endcase
      end
   end

   assign bus.code  = r_code;
   assign bus.valid = r_valid;
   assign bus.busy  = r_busy;
   assign bus.done  = r_done;
   assign bus.count = r_count;
endmodule

// File: tb/tb_lut_minterm_enum.sv
// Four enumerators with different truth tables, checked by a code scoreboard and a latency model.
module tb_lut_minterm_enum;
   logic clk = 1'b0;
   logic rst = 1'b1;
   always #5 clk = ~clk;

   localparam logic [15:0] MASKS [4] = '{16'h0510, 16'h8001, 16'h0000, 16'hFFFF};
   int lat_ready1 [4] = '{19, 18, 16, 32};

   lut_minterm_enum_if #(.WIDTH(4)) bus0 ();
   lut_minterm_enum_if #(.WIDTH(4)) bus1 ();
   lut_minterm_enum_if #(.WIDTH(4)) bus2 ();
   lut_minterm_enum_if #(.WIDTH(4)) bus3 ();

   lut_minterm_enum #(.WIDTH(4), .MASK(16'h0510)) u0 (.clk(clk), .rst(rst), .bus(bus0));
   lut_minterm_enum #(.WIDTH(4), .MASK(16'h8001)) u1 (.clk(clk), .rst(rst), .bus(bus1));
   lut_minterm_enum #(.WIDTH(4), .MASK(16'h0000)) u2 (.clk(clk), .rst(rst), .bus(bus2));
   lut_minterm_enum #(.WIDTH(4), .MASK(16'hFFFF)) u3 (.clk(clk), .rst(rst), .bus(bus3));

   logic [3:0] st  = '0;
   logic [3:0] rdy = '0;
   logic [3:0] vld, bsy, dn;
   logic [3:0] cd  [4];
   logic [4:0] cnt [4];

   assign bus0.start = st[0]; assign bus0.ready = rdy[0];
   assign bus1.start = st[1]; assign bus1.ready = rdy[1];
   assign bus2.start = st[2]; assign bus2.ready = rdy[2];
   assign bus3.start = st[3]; assign bus3.ready = rdy[3];
   assign vld[0] = bus0.valid; assign bsy[0] = bus0.busy; assign dn[0] = bus0.done; assign cd[0] = bus0.code; assign cnt[0] = bus0.count;
   assign vld[1] = bus1.valid; assign bsy[1] = bus1.busy; assign dn[1] = bus1.done; assign cd[1] = bus1.code; assign cnt[1] = bus1.count;
   assign vld[2] = bus2.valid; assign bsy[2] = bus2.busy; assign dn[2] = bus2.done; assign cd[2] = bus2.code; assign cnt[2] = bus2.count;
   assign vld[3] = bus3.valid; assign bsy[3] = bus3.busy; assign dn[3] = bus3.done; assign cd[3] = bus3.code; assign cnt[3] = bus3.count;

   int vectors = 0;
   int errs    = 0;
   int cyc     = 0;
   always @(posedge clk) cyc <= cyc + 1;

   int exp_q [4][$];
   int running [4], start_cyc [4], stall [4], kexp [4], done_cyc [4];
   int prev_stall [4], held [4], idle_chk [4], rdy_mode [4];

   task automatic chk(input string name, input int act, input int exp);
      vectors++;
      if (act != exp) begin
         errs++;
         $display("FAIL %s: got %0d, expected %0d (cycle %0d)", name, act, exp, cyc);
      end
   endtask

   // Ready driver: mode 1 = held high, mode 2 = random, mode 0 = driven by the test.
   initial forever begin
      @(posedge clk); #2;
      for (int d = 0; d < 4; d++) begin
         if (rdy_mode[d] == 1) rdy[d] = 1'b1;
         else if (rdy_mode[d] == 2) rdy[d] = 1'($urandom % 2);
      end
   end

   // Monitor: pops the scoreboard on every accepted code and checks done timing/count.
   initial forever begin
      @(negedge clk);
      if (!rst) begin
         for (int d = 0; d < 4; d++) begin
            if (idle_chk[d] != 0) begin
               chk("busy_after_done", int'(bsy[d]), 0);
               idle_chk[d] = 0;
            end
            if (vld[d]) begin
               if (running[d] == 0) chk("valid_outside_run", int'(vld[d]), 0);
               else begin
                  if (prev_stall[d] != 0) chk("code_held", int'(cd[d]), held[d]);
                  if (rdy[d]) begin
                     if (exp_q[d].size() == 0) chk("unexpected_code", int'(cd[d]), -1);
                     else chk("code", int'(cd[d]), exp_q[d].pop_front());
                  end else stall[d]++;
               end
            end
            prev_stall[d] = (vld[d] && !rdy[d]) ? 1 : 0;
            held[d]       = int'(cd[d]);
            if (dn[d]) begin
               if (running[d] == 0) chk("spurious_done", int'(dn[d]), 0);
               else begin
                  done_cyc[d] = cyc;
                  chk("done_cycle", cyc - start_cyc[d], 16 + kexp[d] + stall[d]);
                  chk("count", int'(cnt[d]), kexp[d]);
                  chk("codes_left", exp_q[d].size(), 0);
                  chk("busy_in_done", int'(bsy[d]), 1);
                  running[d]  = 0;
                  idle_chk[d] = 1;
               end
            end
         end
      end
   end

   task automatic launch(input int d, input int hammer);
      @(posedge clk); #2;
      st[d] = 1'b1;
      exp_q[d].delete();
      kexp[d] = 0;
      for (int i = 0; i < 16; i++) begin
         if (MASKS[d][i]) begin
            exp_q[d].push_back(i);
            kexp[d]++;
         end
      end
      stall[d]      = 0;
      prev_stall[d] = 0;
      running[d]    = 1;
      @(posedge clk); #1;
      start_cyc[d] = cyc;
      chk("busy_after_start", int'(bsy[d]), 1);
      #1;
      st[d] = 1'b0;
      if (hammer != 0) begin
         for (int i = 0; i < 10; i++) begin
            @(posedge clk); #2;
            st[d] = 1'($urandom % 2);
         end
         st[d] = 1'b0;
      end
   endtask

   task automatic wait_done(input int d);
      for (int i = 0; i < 3000 && running[d] != 0; i++) @(posedge clk);
      if (running[d] != 0) begin
         chk("done_timeout", running[d], 0);
         running[d] = 0;
      end
      repeat (2) @(posedge clk);
   endtask

   task automatic wait_code8;
      for (int i = 0; i < 100; i++) begin
         @(posedge clk); #2;
         if (vld[0] && cd[0] == 4'd8) break;
      end
   endtask

   initial begin
      #500000;
      $display("FAIL watchdog: simulation time limit reached");
      $fatal(1);
   end

   initial begin
      for (int d = 0; d < 4; d++) rdy_mode[d] = 1;
      repeat (3) @(posedge clk);
      #2;
      for (int d = 0; d < 4; d++) begin
         chk("reset_valid", int'(vld[d]), 0);
         chk("reset_busy",  int'(bsy[d]), 0);
         chk("reset_done",  int'(dn[d]),  0);
         chk("reset_count", int'(cnt[d]), 0);
         chk("reset_code",  int'(cd[d]),  0);
      end
      rst = 1'b0;

      for (int d = 0; d < 4; d++) begin
         launch(d, 0);
         wait_done(d);
         chk("latency_ready_high", done_cyc[d] - start_cyc[d], lat_ready1[d]);
      end

      // Three-cycle stall while code 8 is presented.
      rdy_mode[0] = 0;
      rdy[0]      = 1'b1;
      launch(0, 0);
      wait_code8();
      rdy[0] = 1'b0;
      repeat (3) begin @(posedge clk); #2; end
      rdy[0] = 1'b1;
      wait_done(0);
      chk("latency_stall3", done_cyc[0] - start_cyc[0], 22);

      // Repeated start during a run, then an identical second run.
      rdy_mode[0] = 1;
      launch(0, 1);
      wait_done(0);
      launch(0, 0);
      wait_done(0);
      chk("latency_rerun", done_cyc[0] - start_cyc[0], 19);

      // Asynchronous reset while code 8 is valid.
      rdy_mode[0] = 0;
      rdy[0]      = 1'b1;
      launch(0, 0);
      wait_code8();
      rdy[0] = 1'b0;
      chk("pre_reset_count", int'(cnt[0]), 1);
      #2;
      rst = 1'b1;
      #1;
      chk("async_rst_valid", int'(vld[0]), 0);
      chk("async_rst_busy",  int'(bsy[0]), 0);
      chk("async_rst_count", int'(cnt[0]), 0);
      chk("async_rst_done",  int'(dn[0]),  0);
      running[0] = 0;
      exp_q[0].delete();
      @(posedge clk); #2;
      rst = 1'b0;
      repeat (20) @(posedge clk);
      rdy_mode[0] = 1;
      launch(0, 0);
      wait_done(0);
      chk("latency_after_reset", done_cyc[0] - start_cyc[0], 19);

      // Random backpressure on every truth table.
      for (int r = 0; r < 3; r++) begin
         for (int d = 0; d < 4; d++) begin
            rdy_mode[d] = 2;
            launch(d, 0);
            wait_done(d);
            rdy_mode[d] = 1;
         end
      end

      $display("== %0d vectors applied, %0d miscompares ==", vectors, errs);
      $finish;
   end
endmodule
